imem_loader: RTL and testbench

- Writer side of the instruction memory that the sequential Y86-64 core's fetch stage reads.
- Accepts a framed byte stream (length header, program bytes, XOR checksum) over a valid/ready interface.
- Writes each byte into consecutive instruction-memory byte addresses starting at BASE_ADDR.
- Holds the core stalled (cpu_run low) until a complete, checksum-verified image is resident.

---
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//   Groups the loader's byte-stream handshake and its instruction-memory
//   write port.
//   Stream:  in_valid / in_data (source -> loader), in_ready (loader -> source)
//   Memory:  mem_wr_en / mem_wr_addr / mem_wr_data (loader -> memory)
//   Modports:
//     master - the stream source / memory side (the testbench)
//     slave  - the loader itself
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [7:0]            mem_wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the Y86-64 instruction memory. Accepts a framed byte
//   stream (LEN_LO, LEN_HI, L program bytes, XOR checksum), writes the
//   program bytes to consecutive addresses starting at BASE_ADDR, and holds
//   the core stalled until a checksum-verified image is resident.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset
//     reload      - single-cycle pulse: abort / restart, await a new frame
//     bus         - stream handshake + memory write port (slave modport)
//     cpu_run     - high while a verified image is resident
//     load_done   - one-cycle pulse when the image is verified
//     load_error  - sticky error (bad length or checksum) until reload
//     byte_count  - program bytes written in the current frame
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH = 13,
  parameter int BASE_ADDR  = 0,
  parameter int MEM_BYTES  = 8192
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         reload,
  imem_loader_if.slave bus,
  output logic         cpu_run,
  output logic         load_done,
  output logic         load_error,
  output logic [15:0]  byte_count
);

  typedef enum logic [2:0] {
    S_HDR_LO,
    S_HDR_HI,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  localparam int                    LOAD_LIMIT = MEM_BYTES - BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);

  state_e                state_q,      state_d;
  logic [7:0]            len_lo_q,     len_lo_d;
  logic [15:0]           len_q,        len_d;
  logic [7:0]            chk_q,        chk_d;
  logic [15:0]           byte_count_q, byte_count_d;
  logic                  wr_en_q,      wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q,    wr_addr_d;
  logic [7:0]            wr_data_q,    wr_data_d;
  logic                  done_q,       done_d;

  logic        in_ready;
  logic        accept;
  logic [15:0] hdr_len;

  // NOTE: in_ready also depends on rst_n so the source sees "not ready"
  // for the whole time reset is held, not just after the first edge.
  always_comb begin
    in_ready = rst_n && !reload &&
               (state_q inside {S_HDR_LO, S_HDR_HI, S_LOAD, S_CHK});
  end

  assign accept  = bus.in_valid && in_ready;
  assign hdr_len = {bus.in_data, len_lo_q};

  // NOTE: every signal gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    chk_d        = chk_q;
    byte_count_d = byte_count_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;

    if (reload) begin
      // A write registered last cycle still drains from wr_*_q on its own.
      state_d      = S_HDR_LO;
      chk_d        = 8'h00;
      byte_count_d = 16'h0000;
    end else if (accept) begin
      unique case (state_q)
        S_HDR_LO: begin
          len_lo_d = bus.in_data;
          state_d  = S_HDR_HI;
        end
        S_HDR_HI: begin
          len_d        = hdr_len;
          chk_d        = 8'h00;
          byte_count_d = 16'h0000;
          if ({16'h0000, hdr_len} > 32'(LOAD_LIMIT)) state_d = S_ERR;
          else if (hdr_len == 16'h0000)               state_d = S_CHK;
          else                                        state_d = S_LOAD;
        end
        S_LOAD: begin
          wr_en_d      = 1'b1;
          wr_addr_d    = BASE + ADDR_WIDTH'(byte_count_q);
          wr_data_d    = bus.in_data;
          chk_d        = chk_q ^ bus.in_data;
          byte_count_d = byte_count_q + 16'd1;
          if (byte_count_q + 16'd1 == len_q) state_d = S_CHK;
        end
        S_CHK: begin
          if (bus.in_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        default: ;  // DONE / ERR never accept (in_ready is low)
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_HDR_LO;
      len_lo_q     <= 8'h00;
      len_q        <= 16'h0000;
      chk_q        <= 8'h00;
      byte_count_q <= 16'h0000;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      chk_q        <= chk_d;
      byte_count_q <= byte_count_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;

  // Run / error follow the terminal states, so a reload (next state HDR_LO)
  // clears both on the following cycle.
  assign cpu_run    = (state_q == S_DONE);
  assign load_error = (state_q == S_ERR);
  assign load_done  = done_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Frames are built from program byte
//   lists; a frame-level model derives the expected writes (address, data,
//   cycle), final status and byte count, which are compared against a
//   monitor that records every memory write and load_done pulse.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_WIDTH = 13;
  localparam int BASE_ADDR  = 0;
  localparam int MEM_BYTES  = 8192;
  localparam int LIMIT      = MEM_BYTES - BASE_ADDR;

  typedef logic [7:0] bytes_t [$];
  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data;
    int                    cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reload;
  logic        cpu_run;
  logic        load_done;
  logic        load_error;
  logic [15:0] byte_count;

  imem_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  imem_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR),
    .MEM_BYTES (MEM_BYTES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reload    (reload),
    .bus       (bus),
    .cpu_run   (cpu_run),
    .load_done (load_done),
    .load_error(load_error),
    .byte_count(byte_count)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  done_total = 0;
  int  done_cyc   = -1;
  int  chk_cyc    = -1;
  wr_t act_q[$];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1)
      act_q.push_back('{bus.mem_wr_addr, bus.mem_wr_data, cyc});
    if (load_done === 1'b1) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
  end

  // ---------------- reference model ----------------
  function automatic void make_frame(input bytes_t prog, input logic [7:0] flip,
                                     output bytes_t fr);
    logic [15:0] l;
    logic [7:0]  x;
    l  = 16'(prog.size());
    x  = 8'h00;
    fr = {};
    fr.push_back(l[7:0]);
    fr.push_back(l[15:8]);
    foreach (prog[i]) begin
      fr.push_back(prog[i]);
      x ^= prog[i];
    end
    fr.push_back(x ^ flip);
  endfunction

  // Bytes the loader consumes, whether it ends verified, and its final count.
  function automatic void model(input bytes_t fr, output int n_cons,
                                output bit ok, output int cnt);
    int         l;
    logic [7:0] x;
    l = int'({fr[1], fr[0]});
    if (l > LIMIT) begin
      n_cons = 2; ok = 1'b0; cnt = 0;
    end else begin
      x = 8'h00;
      for (int i = 0; i < l; i++) x ^= fr[2 + i];
      n_cons = l + 3;
      ok     = (fr[l + 2] == x);
      cnt    = l;
    end
  endfunction

  // ---------------- stimulus ----------------
  // mode 0: in_valid held high; 1: toggles every cycle; 2: random.
  task automatic send_bytes(input bytes_t fr, input int first, input int count,
                            input int mode, input string name);
    int k      = first;
    int stall  = 0;
    int l      = int'({fr[1], fr[0]});
    bit tog    = 1'b1;
    bit v;
    while (k < first + count) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? fr[k] : 8'($urandom);
      #1;
      if (v && bus.in_ready === 1'b1) begin
        if (l <= LIMIT && k >= 2 && k < 2 + l)
          exp_q.push_back('{ADDR_WIDTH'(BASE_ADDR + k - 2), fr[k], cyc + 1});
        if (l <= LIMIT && k == 2 + l) chk_cyc = cyc + 1;
        k++;
        stall = 0;
      end else begin
        stall++;
        if (stall > 50) begin
          n_checks++; n_fail++;
          $display("FAIL %s: timeout waiting for in_ready at byte %0d", name, k);
          break;
        end
      end
    end
  endtask

  task automatic check_writes(input string name, input int a0);
    n_checks++;
    if (act_q.size() - a0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s: write count got %0d want %0d", name, act_q.size() - a0,
               exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        n_checks++;
        if (act_q[a0 + i].addr !== exp_q[i].addr || act_q[a0 + i].data !== exp_q[i].data ||
            act_q[a0 + i].cyc != exp_q[i].cyc) begin
          n_fail++;
          $display("FAIL %s: write[%0d] got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                   name, i, act_q[a0 + i].addr, act_q[a0 + i].data, act_q[a0 + i].cyc,
                   exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
        end
      end
    end
  endtask

  // Drives a complete frame, then keeps in_valid high for a few cycles
  // (which must be ignored) before checking the final status.
  task automatic run_frame(input bytes_t fr, input int mode, input string name);
    int n_cons, cnt, a0, d0;
    bit ok;
    model(fr, n_cons, ok, cnt);
    exp_q.delete();
    a0 = act_q.size();
    d0 = done_total;
    chk_cyc = -1;
    send_bytes(fr, 0, n_cons, mode, name);
    repeat (3) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check_writes(name, a0);
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s: in_ready after frame got %b want 0", name, bus.in_ready);
    end
    n_checks++;
    if (cpu_run !== ok) begin
      n_fail++; $display("FAIL %s: cpu_run got %b want %b", name, cpu_run, ok);
    end
    n_checks++;
    if (load_error !== !ok) begin
      n_fail++; $display("FAIL %s: load_error got %b want %b", name, load_error, !ok);
    end
    n_checks++;
    if (byte_count !== 16'(cnt)) begin
      n_fail++; $display("FAIL %s: byte_count got %0d want %0d", name, byte_count, cnt);
    end
    n_checks++;
    if (done_total - d0 != (ok ? 1 : 0)) begin
      n_fail++;
      $display("FAIL %s: load_done cycles got %0d want %0d", name, done_total - d0, ok ? 1 : 0);
    end else if (ok) begin
      n_checks++;
      if (done_cyc != chk_cyc) begin
        n_fail++; $display("FAIL %s: load_done cycle got %0d want %0d", name, done_cyc, chk_cyc);
      end
    end
  endtask

  task automatic do_reload(input string name);
    @(negedge clk);
    reload       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s: in_ready during reload got %b want 0", name, bus.in_ready);
    end
    @(negedge clk);
    reload       = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (load_error !== 1'b0 || cpu_run !== 1'b0 || byte_count !== 16'd0 ||
        bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: after reload got err=%b run=%b count=%0d ready=%b want 0 0 0 1",
               name, load_error, cpu_run, byte_count, bus.in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; reload = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'h04;
    #7;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.mem_wr_en !== 1'b0 || cpu_run !== 1'b0 ||
        load_done !== 1'b0 || load_error !== 1'b0 || byte_count !== 16'd0 ||
        bus.mem_wr_addr !== '0 || bus.mem_wr_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: ready=%b wr=%b run=%b done=%b err=%b count=%0d addr=%h data=%h want all 0",
               bus.in_ready, bus.mem_wr_en, cpu_run, load_done, load_error, byte_count,
               bus.mem_wr_addr, bus.mem_wr_data);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic_frame();
    bytes_t fr;
    // Checksum is the XOR of 30,F0,0A,00 (= 0xCA), built by make_frame.
    make_frame('{8'h30, 8'hF0, 8'h0A, 8'h00}, 8'h00, fr);
    run_frame(fr, 0, "basic_frame");
    do_reload("basic_reload");
  endtask

  task automatic test_toggle_valid();
    bytes_t fr;
    make_frame('{8'h30, 8'hF0, 8'h0A, 8'h00}, 8'h00, fr);
    run_frame(fr, 1, "toggle_valid");
    do_reload("toggle_reload");
  endtask

  task automatic test_bad_checksum();
    bytes_t fr;
    make_frame('{8'h10, 8'h20}, 8'h30, fr);  // CHK byte becomes 0x00
    run_frame(fr, 0, "bad_checksum");
    do_reload("bad_chk_reload");
  endtask

  task automatic test_oversize_header();
    bytes_t fr;
    fr = '{8'h01, 8'h20};  // L = 8193
    run_frame(fr, 0, "oversize_header");
    do_reload("oversize_reload");
  endtask

  task automatic test_max_length_header();
    bytes_t fr;
    int     a0;
    fr = '{8'h00, 8'h20, 8'hA1, 8'hB2, 8'hC3};  // L = 8192 is still legal
    exp_q.delete();
    a0 = act_q.size();
    send_bytes(fr, 0, 5, 0, "max_length");
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check_writes("max_length", a0);
    n_checks++;
    if (bus.in_ready !== 1'b1 || load_error !== 1'b0 || byte_count !== 16'd3) begin
      n_fail++;
      $display("FAIL max_length: ready=%b err=%b count=%0d want 1 0 3",
               bus.in_ready, load_error, byte_count);
    end
    do_reload("max_length_reload");
  endtask

  task automatic test_empty_frame();
    bytes_t fr;
    make_frame('{}, 8'h00, fr);  // 00 00 00
    run_frame(fr, 0, "empty_frame");
    do_reload("empty_reload");
  endtask

  task automatic test_reset_mid_frame();
    bytes_t fr;
    int     a0;
    make_frame('{8'h11, 8'h22, 8'h33, 8'h44}, 8'h00, fr);
    exp_q.delete();
    a0 = act_q.size();
    send_bytes(fr, 0, 4, 0, "rst_mid");
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (byte_count !== 16'd2) begin
      n_fail++; $display("FAIL rst_mid: byte_count before reset got %0d want 2", byte_count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.mem_wr_en !== 1'b0 || cpu_run !== 1'b0 ||
        load_error !== 1'b0 || load_done !== 1'b0 || byte_count !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid: async reset got ready=%b wr=%b run=%b err=%b done=%b count=%0d want all 0",
               bus.in_ready, bus.mem_wr_en, cpu_run, load_error, load_done, byte_count);
    end
    check_writes("rst_mid_partial", a0);
    @(negedge clk);
    rst_n = 1'b1;
    make_frame('{8'h55, 8'h66, 8'h77, 8'h88}, 8'h00, fr);
    run_frame(fr, 0, "after_reset");
    do_reload("after_reset_reload");
  endtask

  task automatic test_reload_during_load();
    bytes_t fr;
    int     a0;
    make_frame('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 8'h00, fr);
    exp_q.delete();
    a0 = act_q.size();
    send_bytes(fr, 0, 4, 0, "reload_mid");
    // Reload right after the 2nd program byte is accepted; its write
    // still lands during the reload cycle.
    do_reload("reload_mid");
    @(negedge clk);
    check_writes("reload_mid_writes", a0);
    make_frame('{8'h9A, 8'hBC, 8'hDE}, 8'h00, fr);
    run_frame(fr, 0, "after_reload");
    do_reload("after_reload_reload");
  endtask

  task automatic test_random_frames();
    bytes_t     prog;
    bytes_t     fr;
    logic [7:0] flip;
    for (int n = 0; n < 16; n++) begin
      prog = {};
      for (int i = 0; i < $urandom_range(0, 24); i++) prog.push_back(8'($urandom));
      flip = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      make_frame(prog, flip, fr);
      run_frame(fr, 2, "random_frame");
      do_reload("random_reload");
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_toggle_valid();
    test_bad_checksum();
    test_oversize_header();
    test_max_length_header();
    test_empty_frame();
    test_reset_mid_frame();
    test_reload_during_load();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
